// File: rtl/mux_pkg.sv
// Shared types and helpers for the pipelined N:1 multiplexer.
package mux_pkg;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} mux_skid_state_t;

    // A 2:1 mux still needs one select bit, so the width never drops below 1.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_comb_n.sv
// Combinational N:1 WIDTH-bit select. A select value of N or more yields all-zero data.
module mux_comb_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = sel_width(N)
) (
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    output logic [WIDTH-1:0]   out_data
);

    always_comb begin
        out_data = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(in_sel) == k) begin
                out_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// N:1 mux with registered valid/ready output and a 2-entry skid buffer.
// Define MUX_SEL_ERR_EN to add the sticky sel_err output for out-of-range selects.
//
// state | meaning
// EMPTY | no word held; out_valid=0
// ONE   | main register holds the output word
// FULL  | main and skid both hold words; in_ready=0
module mux_pipe_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = sel_width(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel
`ifdef MUX_SEL_ERR_EN
    ,
    output logic               sel_err
`endif
);

    mux_skid_state_t  state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SELW-1:0]  main_sel_q, main_sel_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SELW-1:0]  skid_sel_q, skid_sel_d;
    logic [WIDTH-1:0] mux_data;
    logic             in_xfer;
    logic             out_xfer;

    mux_comb_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_mux_comb (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (mux_data)
    );

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_data_d = mux_data;
                    main_sel_d  = in_sel;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = mux_data;
                    main_sel_d  = in_sel;
                end else if (in_xfer) begin
                    skid_data_d = mux_data;
                    skid_sel_d  = in_sel;
                    state_d     = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered copies of the next state.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;

`ifdef MUX_SEL_ERR_EN
    // With N a power of two every select is in range, so the flag folds to 0.
    localparam bit SEL_OOR_POSSIBLE = (N != (1 << SELW));

    logic sel_oor;
    logic sel_err_q, sel_err_d;

    assign sel_oor   = SEL_OOR_POSSIBLE && (int'(in_sel) >= N);
    assign sel_err_d = sel_err_q | (in_xfer & sel_oor);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: instance A (N=4, WIDTH=64) and instance B (N=5, WIDTH=8).
module tb_mux_pipe_n;

    localparam int WA = 64;
    localparam int NA = 4;
    localparam int SA = 2;
    localparam int WB = 8;
    localparam int NB = 5;
    localparam int SB = 3;

    typedef struct packed {
        logic [63:0] d;
        logic [2:0]  s;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;

    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [NA*WA-1:0] a_in_data;
    logic [SA-1:0]    a_in_sel, a_out_sel;
    logic [WA-1:0]    a_out_data;

    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [NB*WB-1:0] b_in_data;
    logic [SB-1:0]    b_in_sel, b_out_sel;
    logic [WB-1:0]    b_out_data;
`ifdef MUX_SEL_ERR_EN
    logic             a_sel_err, b_sel_err;
`endif

    exp_t        qa[$];
    exp_t        qb[$];
    logic [63:0] exp_a_d, exp_b_d;
    logic [2:0]  exp_a_s, exp_b_s;
    logic        acc_a, acc_b;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] ch[4];

    always #5 clk = ~clk;

    mux_pipe_n #(.WIDTH(WA), .N(NA)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sel    (a_in_sel),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (a_sel_err)
`endif
    );

    mux_pipe_n #(.WIDTH(WB), .N(NB)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sel    (b_in_sel),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel)
`ifdef MUX_SEL_ERR_EN
        ,
        .sel_err   (b_sel_err)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock: record accepted offers at the negedge, then advance to just after the edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        acc_a = a_in_valid && a_in_ready;
        acc_b = b_in_valid && b_in_ready;
        if (acc_a) begin
            e.d = exp_a_d;
            e.s = exp_a_s;
            qa.push_back(e);
        end
        if (acc_b) begin
            e.d = exp_b_d;
            e.s = exp_b_s;
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [SA-1:0] sel, input logic [63:0] expd);
        int n;
        a_in_valid = 1'b1;
        a_in_sel   = sel;
        exp_a_d    = expd;
        exp_a_s    = {1'b0, sel};
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_a && n < 50);
        if (!acc_a) chk("a_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic offer_b(input logic [SB-1:0] sel, input logic [63:0] expd);
        int n;
        b_in_valid = 1'b1;
        b_in_sel   = sel;
        exp_b_d    = expd;
        exp_b_s    = sel;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_b && n < 50);
        if (!acc_b) chk("b_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    // Monitor: pops and compares on every output transfer, and checks output stability while stalled.
    initial begin
        exp_t        e;
        logic        a_st = 1'b0, b_st = 1'b0;
        logic [63:0] a_st_d = '0, b_st_d = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                a_st = 1'b0;
                b_st = 1'b0;
            end else begin
                if (a_st) begin
                    chk("a_stall_valid", 64'(a_out_valid), 64'd1);
                    chk("a_stall_data", a_out_data, a_st_d);
                end
                if (b_st) begin
                    chk("b_stall_valid", 64'(b_out_valid), 64'd1);
                    chk("b_stall_data", 64'(b_out_data), b_st_d);
                end
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) chk("a_unexpected_word", 64'd1, 64'd0);
                    else begin
                        e = qa.pop_front();
                        chk("a_data", a_out_data, e.d);
                        chk("a_sel", 64'(a_out_sel), 64'(e.s));
                    end
                end
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) chk("b_unexpected_word", 64'd1, 64'd0);
                    else begin
                        e = qb.pop_front();
                        chk("b_data", 64'(b_out_data), e.d);
                        chk("b_sel", 64'(b_out_sel), 64'(e.s));
                    end
                end
                a_st   = a_out_valid && !a_out_ready;
                a_st_d = a_out_data;
                b_st   = b_out_valid && !b_out_ready;
                b_st_d = 64'(b_out_data);
            end
        end
    end

    initial begin
        logic [SA-1:0] s;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_in_sel = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_in_sel = '0;
        exp_a_d = '0; exp_a_s = '0; exp_b_d = '0; exp_b_s = '0;
        acc_a = 1'b0; acc_b = 1'b0;

        // Reset held with random inputs
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            a_in_sel    = 2'($urandom_range(0, 3));
            b_in_valid  = 1'($urandom_range(0, 1));
        end
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_data", a_out_data, 64'd0);
        chk("rst_out_sel", 64'(a_out_sel), 64'd0);
        chk("rst_b_out_valid", 64'(b_out_valid), 64'd0);
`ifdef MUX_SEL_ERR_EN
        chk("rst_b_sel_err", 64'(b_sel_err), 64'd0);
`endif
        a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", 64'(a_in_ready), 64'd1);

        // Stream A0..A3 at full rate
        a_in_data = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        offer_a(2'd0, 64'hA0);
        chk("lat_valid", 64'(a_out_valid), 64'd1);
        chk("lat_data", a_out_data, 64'hA0);
        offer_a(2'd1, 64'hA1);
        chk("stream_data1", a_out_data, 64'hA1);
        offer_a(2'd2, 64'hA2);
        offer_a(2'd3, 64'hA3);
        drain();

        // Backpressure: two accepted, third waits until the first drain
        a_out_ready = 1'b0;
        a_in_data = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        offer_a(2'd0, 64'hB0);
        offer_a(2'd1, 64'hB1);
        chk("bp_full_ready", 64'(a_in_ready), 64'd0);
        a_in_sel = 2'd2;
        exp_a_d = 64'hB2;
        exp_a_s = 3'd2;
        tick();
        tick();
        chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
        chk("bp_hold_data", a_out_data, 64'hB0);
        a_out_ready = 1'b1;
        tick();
        chk("bp_ready_back", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_third_acc", 64'(acc_a), 64'd1);
        drain();

        // Out-of-range select on the N=5 instance
        b_in_data = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        offer_b(3'd0, 64'h10);
        offer_b(3'd1, 64'h11);
        offer_b(3'd2, 64'h12);
        offer_b(3'd3, 64'h13);
        offer_b(3'd4, 64'h14);
`ifdef MUX_SEL_ERR_EN
        chk("b_sel_err_pre", 64'(b_sel_err), 64'd0);
`endif
        offer_b(3'd7, 64'h00);
`ifdef MUX_SEL_ERR_EN
        chk("b_sel_err_set", 64'(b_sel_err), 64'd1);
`endif
        chk("b_oor_data", 64'(b_out_data), 64'h00);
        chk("b_oor_sel", 64'(b_out_sel), 64'd7);
        offer_b(3'd5, 64'h00);
        offer_b(3'd2, 64'h12);
        drain();
`ifdef MUX_SEL_ERR_EN
        chk("b_sel_err_sticky", 64'(b_sel_err), 64'd1);
        chk("a_sel_err_zero", 64'(a_sel_err), 64'd0);
`endif

        // Random valid/ready traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) ch[k] = {$urandom, $urandom};
            s = 2'($urandom_range(0, 3));
            a_in_data   = {ch[3], ch[2], ch[1], ch[0]};
            a_in_sel    = s;
            a_in_valid  = 1'($urandom_range(0, 1));
            a_out_ready = ($urandom_range(0, 3) != 0);
            exp_a_d     = ch[s];
            exp_a_s     = {1'b0, s};
            tick();
        end
        drain();

        // Reset asserted while FULL
        a_out_ready = 1'b0;
        a_in_data = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        offer_a(2'd2, 64'hC2);
        offer_a(2'd3, 64'hC3);
        a_in_valid = 1'b0;
        chk("full_before_rst", 64'(a_in_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(a_out_valid), 64'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("post_rst_valid", 64'(a_out_valid), 64'd0);
        chk("post_rst_ready", 64'(a_in_ready), 64'd1);
`ifdef MUX_SEL_ERR_EN
        chk("post_rst_sel_err", 64'(b_sel_err), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
